// File: rtl/ema_pkg.sv
// Shared definitions for the EMA filter chain: level-detector state encoding,
// default sample width and the effective debounce-length rule.
package ema_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      RISE_PEND = 2'd1,
      HIGH      = 2'd2,
      FALL_PEND = 2'd3
   } det_state_t;

   // A debounce length of zero behaves exactly like a length of one.
   function automatic int unsigned eff_deb_len(input int unsigned len);
      return (len == 32'd0) ? 32'd1 : len;
   endfunction

endpackage

// File: rtl/ema_det_debounce.sv
// Debounce counter shared by the rise and fall pending states; done means the
// next qualifying sample reaches the effective debounce length.
module ema_det_debounce
   import ema_pkg::*;
#(
   parameter int DEB_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   input  logic [DEB_W-1:0] deb_len,
   output logic             done
);

   logic [DEB_W-1:0] cnt;
   logic [DEB_W:0]   cnt_plus1;

   // Compare with >= so that shrinking deb_len mid-pending completes at once.
   always_comb begin
      cnt_plus1 = {1'b0, cnt} + 1'b1;
      done      = 32'(cnt_plus1) >= eff_deb_len(32'(deb_len));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt_plus1[DEB_W-1:0];
      end
   end

endmodule

// File: rtl/ema_level_detector.sv
// Debounced hysteretic level detector on the EMA output stream, with rise/fall
// pulses and a saturating rise counter. Optional peak hold: LEVEL_DET_PEAK_HOLD_EN.
module ema_level_detector
   import ema_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEB_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] y_in,
   input  logic             y_valid,
   input  logic [WIDTH-1:0] thr_hi,
   input  logic [WIDTH-1:0] thr_lo,
   input  logic [DEB_W-1:0] deb_len,
   input  logic             clr_cnt,
   output logic             level,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] evt_cnt,
   output logic             cfg_err
`ifdef LEVEL_DET_PEAK_HOLD_EN
   ,
   output logic [WIDTH-1:0] peak
`endif
);

   det_state_t state, state_next;
   logic advance, rise_q, fall_q;
   logic deb_inc, deb_clr, deb_done;
   logic rise_evt, fall_evt;

   ema_det_debounce #(.DEB_W(DEB_W)) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .inc     (deb_inc),
      .clr     (deb_clr),
      .deb_len (deb_len),
      .done    (deb_done)
   );

   always_comb begin
      state_next = state;
      deb_inc    = 1'b0;
      deb_clr    = 1'b0;
      rise_evt   = 1'b0;
      fall_evt   = 1'b0;
      advance    = y_valid && !cfg_err;
      rise_q     = y_in >= thr_hi;
      fall_q     = y_in <= thr_lo;
      if (advance) begin
         case (state)
            LOW, RISE_PEND: begin
               if (!rise_q) begin
                  state_next = LOW;
                  deb_clr    = 1'b1;
               end else if (deb_done) begin
                  state_next = HIGH;
                  deb_clr    = 1'b1;
                  rise_evt   = 1'b1;
               end else begin
                  state_next = RISE_PEND;
                  deb_inc    = 1'b1;
               end
            end
            HIGH, FALL_PEND: begin
               if (!fall_q) begin
                  state_next = HIGH;
                  deb_clr    = 1'b1;
               end else if (deb_done) begin
                  state_next = LOW;
                  deb_clr    = 1'b1;
                  fall_evt   = 1'b1;
               end else begin
                  state_next = FALL_PEND;
                  deb_inc    = 1'b1;
               end
            end
            default: begin
               state_next = LOW;
               deb_clr    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= LOW;
         level      <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         evt_cnt    <= '0;
         cfg_err    <= 1'b0;
      end else begin
         state      <= state_next;
         level      <= (state_next == HIGH) || (state_next == FALL_PEND);
         rise_pulse <= rise_evt;
         fall_pulse <= fall_evt;
         cfg_err    <= thr_lo > thr_hi;
         // Clear wins over a coincident rise; the count sticks at all-ones.
         if (clr_cnt) begin
            evt_cnt <= '0;
         end else if (rise_evt && (evt_cnt != '1)) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
         end
      end
   end

`ifdef LEVEL_DET_PEAK_HOLD_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peak <= '0;
      end else if (rise_evt) begin
         peak <= '0;
      end else if (level && y_valid && (y_in > peak)) begin
         peak <= y_in;
      end
   end
`endif

endmodule

// File: tb/tb_ema_level_detector.sv
// Directed bench for ema_level_detector (CNT_W=2 so saturation is reachable);
// peak checks are compiled in when LEVEL_DET_PEAK_HOLD_EN is defined.
module tb_ema_level_detector;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] y_in = '0;
   logic       y_valid = 1'b0;
   logic [7:0] thr_hi = 8'd100;
   logic [7:0] thr_lo = 8'd60;
   logic [3:0] deb_len = 4'd3;
   logic       clr_cnt = 1'b0;
   logic       level, rise_pulse, fall_pulse, cfg_err;
   logic [1:0] evt_cnt;
`ifdef LEVEL_DET_PEAK_HOLD_EN
   logic [7:0] peak;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic       vld;
      logic [7:0] y;
      logic       lvl;
      logic       rise;
      logic       fall;
      logic [1:0] cnt;
   } vec_t;

   vec_t tbl[$];

   ema_level_detector #(.WIDTH(8), .DEB_W(4), .CNT_W(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .y_in       (y_in),
      .y_valid    (y_valid),
      .thr_hi     (thr_hi),
      .thr_lo     (thr_lo),
      .deb_len    (deb_len),
      .clr_cnt    (clr_cnt),
      .level      (level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .evt_cnt    (evt_cnt),
      .cfg_err    (cfg_err)
`ifdef LEVEL_DET_PEAK_HOLD_EN
      ,
      .peak       (peak)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic lvl, input logic r,
                          input logic f, input logic [1:0] cnt);
      chk({name, ".level"}, int'(level), int'(lvl));
      chk({name, ".rise"}, int'(rise_pulse), int'(r));
      chk({name, ".fall"}, int'(fall_pulse), int'(f));
      chk({name, ".evt_cnt"}, int'(evt_cnt), int'(cnt));
   endtask

   task automatic step(input logic v, input logic [7:0] y);
      y_valid = v;
      y_in    = y;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic v, input logic [7:0] y, input logic l,
                      input logic r, input logic f, input logic [1:0] c);
      vec_t e;
      e.vld = v; e.y = y; e.lvl = l; e.rise = r; e.fall = f; e.cnt = c;
      tbl.push_back(e);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);
      chk("reset.cfg_err", int'(cfg_err), 0);
      reset = 1'b0;

      // Reset in the middle of a rise debounce discards progress
      step(1'b1, 8'd120);
      step(1'b1, 8'd120);
      chk_out("pend2", 1'b0, 1'b0, 1'b0, 2'd0);
      reset = 1'b1;
      #2;
      chk_out("mid_reset", 1'b0, 1'b0, 1'b0, 2'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b1, 8'd120);
      chk_out("fresh1", 1'b0, 1'b0, 1'b0, 2'd0);
      step(1'b1, 8'd120);
      chk_out("fresh2", 1'b0, 1'b0, 1'b0, 2'd0);
      step(1'b1, 8'd120);
      chk_out("fresh3_rise", 1'b1, 1'b1, 1'b0, 2'd1);

      // Hysteresis band, fall debounce, restart on a break, valid gaps
      for (int i = 0; i < 10; i++) add(1'b1, 8'd80, 1'b1, 1'b0, 1'b0, 2'd1);
      add(1'b1, 8'd50, 1'b1, 1'b0, 1'b0, 2'd1);
      add(1'b1, 8'd50, 1'b1, 1'b0, 1'b0, 2'd1);
      add(1'b1, 8'd50, 1'b0, 1'b0, 1'b1, 2'd1);
      add(1'b1, 8'd50, 1'b0, 1'b0, 1'b0, 2'd1);
      add(1'b1, 8'd120, 1'b0, 1'b0, 1'b0, 2'd1);
      add(1'b1, 8'd120, 1'b0, 1'b0, 1'b0, 2'd1);
      add(1'b1, 8'd90, 1'b0, 1'b0, 1'b0, 2'd1);
      add(1'b1, 8'd120, 1'b0, 1'b0, 1'b0, 2'd1);
      add(1'b1, 8'd120, 1'b0, 1'b0, 1'b0, 2'd1);
      add(1'b0, 8'd120, 1'b0, 1'b0, 1'b0, 2'd1);
      add(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd1);
      add(1'b1, 8'd120, 1'b1, 1'b1, 1'b0, 2'd2);
      add(1'b1, 8'd200, 1'b1, 1'b0, 1'b0, 2'd2);
      add(1'b1, 8'd50, 1'b1, 1'b0, 1'b0, 2'd2);
      add(1'b1, 8'd50, 1'b1, 1'b0, 1'b0, 2'd2);
      add(1'b1, 8'd50, 1'b0, 1'b0, 1'b1, 2'd2);
      foreach (tbl[i]) begin
         step(tbl[i].vld, tbl[i].y);
         chk_out($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].cnt);
      end

      // Bad threshold configuration freezes the detector
      thr_lo = 8'd110;
      step(1'b0, 8'd0);
      chk("cfg_err_set", int'(cfg_err), 1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'd200);
         chk_out($sformatf("cfg_frozen%0d", i), 1'b0, 1'b0, 1'b0, 2'd2);
      end
      thr_lo = 8'd60;
      step(1'b1, 8'd200);
      chk("cfg_err_clr", int'(cfg_err), 0);
      chk_out("cfg_lag", 1'b0, 1'b0, 1'b0, 2'd2);
      step(1'b1, 8'd200);
      step(1'b1, 8'd200);
      chk_out("resume_pend", 1'b0, 1'b0, 1'b0, 2'd2);
      step(1'b1, 8'd200);
      chk_out("resume_rise", 1'b1, 1'b1, 1'b0, 2'd3);

      // deb_len of zero acts as one; the fourth rise saturates the counter
      deb_len = 4'd0;
      step(1'b1, 8'd50);
      chk_out("deb0_fall", 1'b0, 1'b0, 1'b1, 2'd3);
      step(1'b1, 8'd120);
      chk_out("deb0_rise_sat", 1'b1, 1'b1, 1'b0, 2'd3);

      // Shrinking deb_len mid-pending completes on the next qualifier
      deb_len = 4'd5;
      step(1'b1, 8'd50);
      step(1'b1, 8'd50);
      chk_out("pend_len5", 1'b1, 1'b0, 1'b0, 2'd3);
      deb_len = 4'd2;
      step(1'b1, 8'd50);
      chk_out("shrink_fall", 1'b0, 1'b0, 1'b1, 2'd3);

      // Fifth rise stays saturated; clr_cnt wins over the sixth rise
      deb_len = 4'd1;
      step(1'b1, 8'd120);
      chk_out("rise5_sat", 1'b1, 1'b1, 1'b0, 2'd3);
      step(1'b1, 8'd50);
      chk_out("fall5", 1'b0, 1'b0, 1'b1, 2'd3);
      clr_cnt = 1'b1;
      step(1'b1, 8'd120);
      clr_cnt = 1'b0;
      chk_out("rise6_clr", 1'b1, 1'b1, 1'b0, 2'd0);
      step(1'b1, 8'd120);
      chk_out("after_clr", 1'b1, 1'b0, 1'b0, 2'd0);

`ifdef LEVEL_DET_PEAK_HOLD_EN
      step(1'b1, 8'd50);
      step(1'b1, 8'd120);
      chk("peak_cleared", int'(peak), 0);
      step(1'b1, 8'd120);
      chk("peak_120", int'(peak), 120);
      step(1'b1, 8'd180);
      chk("peak_180", int'(peak), 180);
      step(1'b1, 8'd150);
      chk("peak_hold_150", int'(peak), 180);
      step(1'b1, 8'd50);
      step(1'b1, 8'd30);
      chk("peak_low_hold", int'(peak), 180);
      step(1'b1, 8'd120);
      chk("peak_rise_clear", int'(peak), 0);
      step(1'b1, 8'd130);
      chk("peak_130", int'(peak), 130);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
